// File: rtl/decode_stage_buffer.sv
// decode_stage_buffer: decodes RV instructions into fields/immediates and queues
// the decoded records in a DEPTH-entry FIFO with valid/ready on both sides.
module decode_stage_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal,
    output logic [XLEN-1:0] out_pc
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] imm_q   [DEPTH];
    logic [2:0]      type_q  [DEPTH];
    logic            ill_q   [DEPTH];
    logic [2:0]      d_type;
    logic            d_legal;
    logic [31:0]     d_imm32;
    logic [31:0]     h_instr;
    logic            enq, deq;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Unlisted opcodes (including any with instr[1:0] != 2'b11) stay type 0 and flag illegal.
    always_comb begin
        d_legal = 1'b1;
        d_type  = 3'd0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: d_type = 3'd1;
            7'b0100011:             d_type = 3'd2;
            7'b1100011:             d_type = 3'd3;
            7'b0110111, 7'b0010111: d_type = 3'd4;
            7'b1101111:             d_type = 3'd5;
            7'b0110011, 7'b0111011: d_type = 3'd0;
            default:                d_legal = 1'b0;
        endcase
        d_imm32 = d_type == 3'd1 ? {{20{in_instr[31]}}, in_instr[31:20]} :
                  d_type == 3'd2 ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                  d_type == 3'd3 ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                  d_type == 3'd4 ? {in_instr[31:12], 12'b0} :
                  d_type == 3'd5 ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                  32'd0;
    end

    assign in_ready  = count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                imm_q[i]   <= '0;
                type_q[i]  <= '0;
                ill_q[i]   <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                instr_q[wr_ptr] <= in_instr;
                pc_q[wr_ptr]    <= in_pc;
                imm_q[wr_ptr]   <= XLEN'($signed(d_imm32));
                type_q[wr_ptr]  <= d_type;
                ill_q[wr_ptr]   <= !d_legal;
                wr_ptr          <= nxt(wr_ptr);
            end
            if (deq) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    assign h_instr  = out_valid ? instr_q[rd_ptr] : '0;
    assign opcode   = h_instr[6:0];
    assign rd       = h_instr[11:7];
    assign func3    = h_instr[14:12];
    assign rs1      = h_instr[19:15];
    assign rs2      = h_instr[24:20];
    assign func7    = h_instr[31:25];
    assign imm      = out_valid ? imm_q[rd_ptr] : '0;
    assign imm_type = out_valid ? type_q[rd_ptr] : '0;
    assign illegal  = out_valid && ill_q[rd_ptr];
    assign out_pc   = out_valid ? pc_q[rd_ptr] : '0;
endmodule

// File: tb/tb_decode_stage_buffer.sv
// tb_decode_stage_buffer: vector table, directed FIFO corner cases and random traffic
// checked against a queue-based reference with arithmetic immediate decoding.
module tb_decode_stage_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int NV    = 13;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, flush, out_valid, out_ready, illegal;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc, imm, out_pc;
    logic [6:0]      opcode, func7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      func3, imm_type;

    decode_stage_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1),
        .rs2(rs2), .func7(func7), .imm(imm), .imm_type(imm_type), .illegal(illegal),
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  t;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t        vecs [NV];
    logic [63:0] q [$];
    int          tests = 0;
    int          fails = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference decoding: immediate assembled as an integer, then two's-complement wrapped.
    function automatic void model_dec(input logic [31:0] i, output logic [2:0] t,
                                      output logic [31:0] im, output logic ill);
        int v;
        v = 0; t = 3'd0; ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
                t = 3'd1; v = int'(i[31:20]); if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                t = 3'd2; v = int'(i[31:25]) * 32 + int'(i[11:7]); if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                t = 3'd3;
                v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: begin
                t = 3'd4; v = int'({i[31:12], 12'h000});
            end
            7'h6F: begin
                t = 3'd5;
                v = int'(i[31]) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            7'h33, 7'h3B: t = 3'd0;
            default: ill = 1'b1;
        endcase
        im = 32'(v);
    endfunction

    task automatic tick();
        bit          acc, deq, clr;
        logic [63:0] e;
        clr = !reset || flush;
        acc = reset && in_valid && q.size() < DEPTH;
        deq = reset && out_ready && q.size() > 0;
        e   = {in_pc, in_instr};
        @(posedge clk);
        if (clr) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic check_head(string tag);
        logic [31:0] i, pc, im;
        logic [2:0]  t;
        logic        ill, v;
        v = q.size() > 0;
        i = '0; pc = '0; im = '0; t = '0; ill = 1'b0;
        if (v) begin
            {pc, i} = q[0];
            model_dec(i, t, im, ill);
        end
        chk({tag, ".out_valid"}, out_valid, v);
        chk({tag, ".in_ready"}, in_ready, q.size() < DEPTH);
        chk({tag, ".fields"}, {func7, rs2, rs1, func3, rd, opcode}, i);
        chk({tag, ".imm"}, imm, im);
        chk({tag, ".imm_type"}, imm_type, t);
        chk({tag, ".illegal"}, illegal, ill);
        chk({tag, ".out_pc"}, out_pc, pc);
    endtask

    initial begin
        vecs[0]  = '{32'hFFB10093, 3'd1, 32'hFFFFFFFB, 1'b0};
        vecs[1]  = '{32'h00512423, 3'd2, 32'h00000008, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0};
        vecs[3]  = '{32'h123451B7, 3'd4, 32'h12345000, 1'b0};
        vecs[4]  = '{32'h00000000, 3'd0, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h002080B3, 3'd0, 32'h00000000, 1'b0};
        vecs[6]  = '{32'h0080006F, 3'd5, 32'h00000008, 1'b0};
        vecs[7]  = '{32'h00001097, 3'd4, 32'h00001000, 1'b0};
        vecs[8]  = '{32'h00000073, 3'd1, 32'h00000000, 1'b0};
        vecs[9]  = '{32'h0000007F, 3'd0, 32'h00000000, 1'b1};
        vecs[10] = '{32'h00000011, 3'd0, 32'h00000000, 1'b1};
        vecs[11] = '{32'h8000001B, 3'd1, 32'hFFFFF800, 1'b0};
        vecs[12] = '{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 1'b0};

        reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_head("reset");
        reset = 1'b1;
        tick();
        check_head("idle");

        for (int k = 0; k < NV; k++) begin
            in_valid = 1'b1; in_instr = vecs[k].instr; in_pc = 32'(32'h1000 + k * 4);
            tick();
            in_valid = 1'b0;
            chk("tab.opcode", opcode, vecs[k].instr[6:0]);
            chk("tab.imm", imm, vecs[k].imm);
            chk("tab.imm_type", imm_type, vecs[k].t);
            chk("tab.illegal", illegal, vecs[k].ill);
            check_head("tab");
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_head("tab_drain");
        end

        in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h00512423; in_pc = 32'h200;
        tick();
        in_instr = 32'hFE000EE3; in_pc = 32'h204; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("sw.rs1", rs1, 5'd2);
        chk("sw.rs2", rs2, 5'd5);
        chk("sw.imm", imm, 32'd8);
        chk("sw.imm_type", imm_type, 3'd2);
        out_ready = 1'b1;
        tick();
        chk("beq.imm", imm, 32'hFFFFFFFC);
        chk("beq.imm_type", imm_type, 3'd3);
        check_head("beq");
        tick();
        out_ready = 1'b0;
        check_head("order_empty");

        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1; in_instr = vecs[k].instr; in_pc = 32'(32'h300 + k * 4);
            tick();
        end
        chk("full.in_ready", in_ready, 1'b0);
        in_instr = 32'h123451B7;
        tick();
        check_head("full_extra");
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("full_deq.in_ready", in_ready, 1'b1);
        check_head("full_deq");
        out_ready = 1'b1;
        repeat (DEPTH) begin
            tick();
            check_head("drain");
        end
        out_ready = 1'b0;

        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_instr = vecs[k + 5].instr; in_pc = 32'(32'h400 + k * 4);
            tick();
        end
        flush = 1'b1; in_instr = 32'h123451B7; in_pc = 32'h500;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", out_valid, 1'b0);
        check_head("flush");
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lui.imm", imm, 32'h12345000);
        chk("lui.imm_type", imm_type, 3'd4);
        chk("lui.rd", rd, 5'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h600;
        tick();
        in_valid = 1'b0;
        chk("zero.illegal", illegal, 1'b1);
        chk("zero.imm", imm, 32'd0);
        #2 reset = 1'b0;
        #1;
        q.delete();
        check_head("async_reset");
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_head("post_reset");

        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = $urandom_range(0, 1) ? vecs[$urandom_range(0, NV - 1)].instr : $urandom;
            in_pc     = $urandom;
            tick();
            check_head("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
